// File: rtl/uart_rx_periph_if.sv
// uart_rx_periph_if: MEM-stage data-bus signals for the UART receiver peripheral.
interface uart_rx_periph_if;
  logic rd;
  logic wr;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  modport master(output rd, wr, addr, wdata, input rdata);
  modport slave(input rd, wr, addr, wdata, output rdata);
endinterface

// File: rtl/uart_rx_periph.sv
// uart_rx_periph: memory-mapped 16x-oversampling UART receiver with byte FIFO and IRQ.
// Define UART_RX_PARITY_EN to add an even-parity bit between data and stop.
module uart_rx_periph #(
  parameter logic [31:0] BASE_ADDR = 32'h4000_0020,
  parameter int BAUD_DIV = 651,
  parameter int FIFO_DEPTH = 4
) (
  input logic CLK,
  input logic Reset_n,
  uart_rx_periph_if.slave bus,
  input logic in,
  output logic irqout
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, BREAK} state_t;
  state_t state, state_n;
  logic s1, s2, tick;
  logic [15:0] cnt;
  logic [3:0] tc, tc_n;
  logic [2:0] bi, bi_n;
  logic [7:0] sh, sh_n;
  logic pbad, pbad_n, push, ferr_set, perr_set;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] wp, rp;
  logic [AW:0] count;
  logic ne, full, sel0, sel1, sel2, pop, wen, ovr_set, clr, irq_en, ovr, ferr, perr;
  logic unused_wdata;
  assign tick = cnt == 16'(BAUD_DIV - 1);
  assign ne = count != '0;
  assign full = count == (AW + 1)'(FIFO_DEPTH);
  assign sel0 = bus.addr == BASE_ADDR;
  assign sel1 = bus.addr == BASE_ADDR + 32'd4;
  assign sel2 = bus.addr == BASE_ADDR + 32'd8;
  assign pop = bus.rd & sel0 & ne;
  assign wen = push & (!full | pop);
  assign ovr_set = push & full & !pop;
  assign clr = bus.wr & sel1;
  assign unused_wdata = ^{bus.wdata[31:5], bus.wdata[1]};
  assign bus.rdata = !bus.rd ? '0 :
                     sel0 ? {24'b0, ne ? mem[rp] : 8'h00} :
                     sel1 ? {27'b0, perr, ferr, ovr, full, ne} :
                     sel2 ? {31'b0, irq_en} : '0;
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      state <= IDLE;
      {s1, s2} <= 2'b11;
      cnt <= '0;
      tc <= '0;
      bi <= '0;
      sh <= '0;
      pbad <= 1'b0;
    end else begin
      state <= state_n;
      {s1, s2} <= {in, s1};
      cnt <= tick ? '0 : cnt + 16'd1;
      tc <= tc_n;
      bi <= bi_n;
      sh <= sh_n;
      pbad <= pbad_n;
    end
  end
  // Every state advances only on an oversample tick; tc counts ticks within a bit.
  always_comb begin
    state_n = state;
    tc_n = tc;
    bi_n = bi;
    sh_n = sh;
    pbad_n = pbad;
    push = 1'b0;
    ferr_set = 1'b0;
    perr_set = 1'b0;
    if (tick) begin
      tc_n = tc + 4'd1;
      case (state)
        IDLE: begin
          tc_n = '0;
          state_n = s2 ? IDLE : START;
        end
        START: if (tc == 4'd7) begin
          tc_n = '0;
          bi_n = '0;
          pbad_n = 1'b0;
          state_n = s2 ? IDLE : DATA;
        end
        DATA: if (tc == 4'd15) begin
          sh_n = {s2, sh[7:1]};
          bi_n = bi + 3'd1;
`ifdef UART_RX_PARITY_EN
          state_n = bi == 3'd7 ? PARITY : DATA;
`else
          state_n = bi == 3'd7 ? STOP : DATA;
`endif
        end
`ifdef UART_RX_PARITY_EN
        PARITY: if (tc == 4'd15) begin
          pbad_n = s2 != ^sh;
          perr_set = pbad_n;
          state_n = STOP;
        end
`endif
        STOP: if (tc == 4'd15) begin
          push = s2 & !pbad;
          ferr_set = !s2;
          state_n = s2 ? IDLE : BREAK;
        end
        BREAK: state_n = s2 ? IDLE : BREAK;
        default: state_n = IDLE;
      endcase
    end
  end
  always_ff @(posedge CLK) begin
    if (wen) mem[wp] <= sh;
  end
  // Flag set beats a same-cycle write-1-clear.
  always_ff @(posedge CLK) begin
    if (!Reset_n) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
      irq_en <= 1'b0;
      ovr <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
      irqout <= 1'b0;
    end else begin
      if (wen) wp <= wp + 1'b1;
      if (pop) rp <= rp + 1'b1;
      count <= count + (AW + 1)'(wen) - (AW + 1)'(pop);
      if (bus.wr & sel2) irq_en <= bus.wdata[0];
      ovr <= ovr_set | (ovr & ~(clr & bus.wdata[2]));
      ferr <= ferr_set | (ferr & ~(clr & bus.wdata[3]));
      perr <= perr_set | (perr & ~(clr & bus.wdata[4]));
      irqout <= irq_en & ne;
    end
  end
endmodule

// File: tb/tb_uart_rx_periph.sv
// tb_uart_rx_periph: directed self-checking bench for uart_rx_periph (BAUD_DIV=4, FIFO_DEPTH=4).
module tb_uart_rx_periph;
  localparam logic [31:0] BASE = 32'h4000_0020;
  localparam int BIT = 64;
  logic clk, Reset_n, in_line, irqout;
  int checks = 0, fails = 0;
  uart_rx_periph_if bus();
  uart_rx_periph #(.BASE_ADDR(BASE), .BAUD_DIV(4), .FIFO_DEPTH(4)) dut (
    .CLK(clk), .Reset_n(Reset_n), .bus(bus), .in(in_line), .irqout(irqout)
  );
  initial clk = 0;
  always #5 clk = ~clk;
  task automatic bus_read(input logic [31:0] a, output logic [31:0] d);
    @(negedge clk);
    bus.rd = 1;
    bus.addr = a;
    #1 d = bus.rdata;
    @(posedge clk);
    #1 bus.rd = 0;
  endtask
  task automatic bus_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    bus.wr = 1;
    bus.addr = a;
    bus.wdata = v;
    @(posedge clk);
    #1 bus.wr = 0;
  endtask
  task automatic drive_bit(input logic v, input int n);
    in_line = v;
    repeat (n * BIT) @(posedge clk);
  endtask
  task automatic send_head(input logic [7:0] b, input logic p);
    drive_bit(0, 1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], 1);
`ifdef UART_RX_PARITY_EN
    drive_bit(p, 1);
`endif
  endtask
  task automatic send_byte(input logic [7:0] b);
    send_head(b, ^b);
    drive_bit(1, 2);
  endtask
  task automatic test_reset;
    logic [31:0] d;
    Reset_n = 0;
    repeat (3) @(posedge clk);
    #1 Reset_n = 1;
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_status: got %h expected %h", d, 32'h0); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_rxdata: got %h expected %h", d, 32'h0); end
    bus_read(BASE + 8, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL reset_ctrl: got %h expected %h", d, 32'h0); end
    checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL reset_irq: got %b expected 0", irqout); end
    bus_read(BASE + 12, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL unmapped_read: got %h expected %h", d, 32'h0); end
  endtask
  task automatic test_rx_irq;
    logic [31:0] d, st;
    logic found, irq0, irq1;
    found = 0; irq0 = 1'bx; st = 'x;
    bus_write(BASE + 8, 32'hFFFF_FFFF);
    bus_read(BASE + 8, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL ctrl_rw: got %h expected %h", d, 32'h1); end
    send_head(8'hA5, 1'b0);
    in_line = 1;
    for (int i = 0; i < 3 * BIT && !found; i++) begin
      @(negedge clk);
      bus.rd = 1;
      bus.addr = BASE + 4;
      #1;
      if (bus.rdata[0]) begin found = 1; st = bus.rdata; irq0 = irqout; end
    end
    @(negedge clk);
    #1 irq1 = irqout;
    bus.rd = 0;
    checks++; if (found !== 1'b1) begin fails++; $display("FAIL rx_push_seen: got %b expected 1", found); end
    checks++; if (st !== 32'h1) begin fails++; $display("FAIL rx_status: got %h expected %h", st, 32'h1); end
    checks++; if (irq0 !== 1'b0) begin fails++; $display("FAIL irq_latency: got %b expected 0", irq0); end
    checks++; if (irq1 !== 1'b1) begin fails++; $display("FAIL irq_high: got %b expected 1", irq1); end
    bus_read(BASE, d);
    checks++; if (d !== 32'hA5) begin fails++; $display("FAIL rx_data: got %h expected %h", d, 32'hA5); end
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL rx_status_empty: got %h expected %h", d, 32'h0); end
    @(posedge clk);
    #1;
    checks++; if (irqout !== 1'b0) begin fails++; $display("FAIL irq_low: got %b expected 0", irqout); end
    drive_bit(1, 1);
  endtask
  task automatic test_glitch;
    logic [31:0] d;
    in_line = 0;
    repeat (16) @(posedge clk);
    drive_bit(1, 2);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_status: got %h expected %h", d, 32'h0); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL glitch_rxdata: got %h expected %h", d, 32'h0); end
  endtask
  task automatic test_overrun;
    logic [31:0] d;
    for (int i = 1; i <= 5; i++) send_byte(8'(i));
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h7) begin fails++; $display("FAIL ovr_status: got %h expected %h", d, 32'h7); end
    checks++; if (irqout !== 1'b1) begin fails++; $display("FAIL ovr_irq: got %b expected 1", irqout); end
    for (int i = 1; i <= 5; i++) begin
      bus_read(BASE, d);
      checks++; if (d !== (i == 5 ? 32'h0 : 32'(i))) begin fails++; $display("FAIL ovr_read%0d: got %h expected %h", i, d, i == 5 ? 0 : i); end
    end
    bus_write(BASE + 4, 32'h0);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h4) begin fails++; $display("FAIL ovr_keep: got %h expected %h", d, 32'h4); end
    bus_write(BASE + 4, 32'h4);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ovr_clear: got %h expected %h", d, 32'h0); end
  endtask
  task automatic test_frame_err;
    logic [31:0] d;
    send_head(8'h3C, 1'b0);
    drive_bit(0, 2);
    drive_bit(1, 2);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h8) begin fails++; $display("FAIL ferr_status: got %h expected %h", d, 32'h8); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ferr_rxdata: got %h expected %h", d, 32'h0); end
    send_byte(8'h55);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h9) begin fails++; $display("FAIL ferr_next_status: got %h expected %h", d, 32'h9); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h55) begin fails++; $display("FAIL ferr_next_data: got %h expected %h", d, 32'h55); end
    bus_write(BASE + 4, 32'h8);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL ferr_clear: got %h expected %h", d, 32'h0); end
  endtask
`ifdef UART_RX_PARITY_EN
  task automatic test_parity;
    logic [31:0] d;
    send_head(8'h07, 1'b0);
    drive_bit(1, 2);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h10) begin fails++; $display("FAIL perr_status: got %h expected %h", d, 32'h10); end
    bus_write(BASE + 4, 32'h10);
    send_head(8'h07, 1'b1);
    drive_bit(1, 2);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h1) begin fails++; $display("FAIL par_ok_status: got %h expected %h", d, 32'h1); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h07) begin fails++; $display("FAIL par_ok_data: got %h expected %h", d, 32'h07); end
  endtask
`endif
  task automatic test_reset_midframe;
    logic [31:0] d;
    drive_bit(0, 3);
    Reset_n = 0;
    repeat (2) @(posedge clk);
    #1 Reset_n = 1;
    drive_bit(1, 12);
    bus_read(BASE + 4, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL midframe_status: got %h expected %h", d, 32'h0); end
    bus_read(BASE, d);
    checks++; if (d !== 32'h0) begin fails++; $display("FAIL midframe_rxdata: got %h expected %h", d, 32'h0); end
  endtask
  initial begin
    bus.rd = 0; bus.wr = 0; bus.addr = '0; bus.wdata = '0;
    in_line = 1;
    Reset_n = 0;
    test_reset();
    test_rx_irq();
    test_glitch();
    test_overrun();
    test_frame_err();
`ifdef UART_RX_PARITY_EN
    test_parity();
`endif
    test_reset_midframe();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end
endmodule
